// File: rtl/rmw_sequencer_pkg.sv
// Shared constants for the read-modify-write sequencer: ALU modes, RMW op codes,
// FSM states and P register bit positions.
package rmw_sequencer_pkg;

    localparam logic [3:0] ALU_ASL = 4'b1000;
    localparam logic [3:0] ALU_ROL = 4'b1001;
    localparam logic [3:0] ALU_LSR = 4'b1010;
    localparam logic [3:0] ALU_ROR = 4'b1011;
    localparam logic [3:0] ALU_DEC = 4'b1110;
    localparam logic [3:0] ALU_INC = 4'b1111;
    localparam logic [3:0] ALU_STA = 4'b0100;

    localparam logic [2:0] OP_ASL = 3'b000;
    localparam logic [2:0] OP_ROL = 3'b001;
    localparam logic [2:0] OP_LSR = 3'b010;
    localparam logic [2:0] OP_ROR = 3'b011;
    localparam logic [2:0] OP_DEC = 3'b110;
    localparam logic [2:0] OP_INC = 3'b111;

    localparam int P_C = 0;
    localparam int P_Z = 1;
    localparam int P_V = 6;
    localparam int P_N = 7;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_MODIFY = 3'd2,
        ST_WDUMMY = 3'd3,
        ST_WRITE  = 3'd4,
        ST_FIN    = 3'd5
    } state_t;

endpackage

// File: rtl/rmw_sequencer_opmap.sv
// Purpose: decode opcode[7:5] of an RMW instruction into ALU mode and legality.
// Latency: combinational.
// Backpressure: none.
module rmw_opmap
    import rmw_sequencer_pkg::*;
(
    input  logic [2:0] op,
    output logic [3:0] mode,
    output logic       legal
);

    always_comb begin
        mode  = ALU_STA;
        legal = 1'b1;
        case (op)
            OP_ASL:  mode = ALU_ASL;
            OP_ROL:  mode = ALU_ROL;
            OP_LSR:  mode = ALU_LSR;
            OP_ROR:  mode = ALU_ROR;
            OP_DEC:  mode = ALU_DEC;
            OP_INC:  mode = ALU_INC;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/rmw_sequencer.sv
// Purpose: sequences 6502 memory RMW ops (read, ALU modify, write back, flags); RMW_DUMMY_WRITE_EN adds the original-value write.
// Latency: start to done 5 cycles (4 without RMW_DUMMY_WRITE_EN) at zero wait, +1 per mem_ack wait cycle.
// Backpressure: strobes held until mem_ack, abort with err after WAIT_MAX+1 unacked cycles; start ignored while busy.
module rmw_sequencer
    import rmw_sequencer_pkg::*;
#(
    parameter int AW       = 16,
    parameter int WAIT_MAX = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [2:0]    op,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    p_in,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    output logic          mem_we,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata,
    input  logic          mem_ack,
    output logic [3:0]    alu_mode,
    output logic [7:0]    alu_b,
    output logic [7:0]    alu_p,
    input  logic [7:0]    alu_r,
    input  logic [7:0]    alu_f,
    output logic [7:0]    p_out,
    output logic          p_we,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int            WW       = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [WW-1:0] WAIT_CNT = WW'(WAIT_MAX);

    state_t        state;
    logic [WW-1:0] wcnt;
    logic [7:0]    flg;
    logic [3:0]    map_mode;
    logic          map_legal;
    logic          timeout;

    rmw_opmap u_opmap (
        .op    (op),
        .mode  (map_mode),
        .legal (map_legal)
    );

    // wcnt counts unacked strobe cycles of the current access only
    assign timeout = (wcnt == WAIT_CNT) && !mem_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            wcnt      <= '0;
            flg       <= '0;
            mem_addr  <= '0;
            mem_rd    <= 1'b0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            alu_mode  <= ALU_STA;
            alu_b     <= '0;
            alu_p     <= '0;
            p_out     <= '0;
            p_we      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            p_we <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy     <= 1'b1;
                        mem_addr <= addr;
                        alu_p    <= p_in;
                        wcnt     <= '0;
                        if (map_legal) begin
                            alu_mode <= map_mode;
                            mem_rd   <= 1'b1;
                            state    <= ST_READ;
                        end else begin
                            done  <= 1'b1;
                            err   <= 1'b1;
                            state <= ST_FIN;
                        end
                    end
                end
                ST_READ: begin
                    if (mem_ack) begin
                        alu_b  <= mem_rdata;
                        mem_rd <= 1'b0;
                        wcnt   <= '0;
`ifdef RMW_DUMMY_WRITE_EN
                        mem_we    <= 1'b1;
                        mem_wdata <= mem_rdata;
                        state     <= ST_WDUMMY;
`else
                        state     <= ST_MODIFY;
`endif
                    end else if (timeout) begin
                        mem_rd <= 1'b0;
                        done   <= 1'b1;
                        err    <= 1'b1;
                        state  <= ST_FIN;
                    end else begin
                        wcnt <= wcnt + WW'(1);
                    end
                end
`ifdef RMW_DUMMY_WRITE_EN
                ST_WDUMMY: begin
                    if (mem_ack) begin
                        mem_we <= 1'b0;
                        state  <= ST_MODIFY;
                    end else if (timeout) begin
                        mem_we <= 1'b0;
                        done   <= 1'b1;
                        err    <= 1'b1;
                        state  <= ST_FIN;
                    end else begin
                        wcnt <= wcnt + WW'(1);
                    end
                end
`endif
                ST_MODIFY: begin
                    // mem_wdata doubles as the result register
                    mem_wdata <= alu_r;
                    flg       <= alu_f;
                    mem_we    <= 1'b1;
                    wcnt      <= '0;
                    state     <= ST_WRITE;
                end
                ST_WRITE: begin
                    if (mem_ack) begin
                        mem_we <= 1'b0;
                        done   <= 1'b1;
                        p_we   <= 1'b1;
                        p_out  <= flg;
                        state  <= ST_FIN;
                    end else if (timeout) begin
                        mem_we <= 1'b0;
                        done   <= 1'b1;
                        err    <= 1'b1;
                        state  <= ST_FIN;
                    end else begin
                        wcnt <= wcnt + WW'(1);
                    end
                end
                ST_FIN: begin
                    busy     <= 1'b0;
                    alu_mode <= ALU_STA;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rmw_sequencer.sv
// Self-checking bench for rmw_sequencer: directed test-plan steps plus randomized ops against an arithmetic reference model.
module tb_rmw_sequencer;
    import rmw_sequencer_pkg::*;

    localparam int AW       = 16;
    localparam int WAIT_MAX = 15;
`ifdef RMW_DUMMY_WRITE_EN
    localparam int D = 1;
`else
    localparam int D = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [2:0]    op;
    logic [AW-1:0] addr;
    logic [7:0]    p_in;
    logic [AW-1:0] mem_addr;
    logic          mem_rd, mem_we;
    logic [7:0]    mem_wdata, mem_rdata;
    logic          mem_ack;
    logic [3:0]    alu_mode;
    logic [7:0]    alu_b, alu_p, alu_r, alu_f;
    logic [7:0]    p_out;
    logic          p_we, busy, done, err;
    logic          cout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rmw_sequencer #(.AW(AW), .WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .addr(addr), .p_in(p_in),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .alu_mode(alu_mode), .alu_b(alu_b), .alu_p(alu_p), .alu_r(alu_r), .alu_f(alu_f),
        .p_out(p_out), .p_we(p_we), .busy(busy), .done(done), .err(err)
    );

    // External shared ALU, bit-level shift/carry behaviour
    always_comb begin
        alu_r = alu_b;
        alu_f = alu_p;
        cout  = alu_p[P_C];
        case (alu_mode)
            ALU_ASL: {cout, alu_r} = {alu_b, 1'b0};
            ALU_ROL: {cout, alu_r} = {alu_b, alu_p[P_C]};
            ALU_LSR: {alu_r, cout} = {1'b0, alu_b};
            ALU_ROR: {alu_r, cout} = {alu_p[P_C], alu_b};
            ALU_DEC: alu_r = alu_b - 8'd1;
            ALU_INC: alu_r = alu_b + 8'd1;
            ALU_STA: alu_r = alu_b;
            default: alu_r = alu_b;
        endcase
        alu_f[P_C] = cout;
        alu_f[P_Z] = (alu_r == 8'h00);
        alu_f[P_N] = alu_r[7];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: what memory and P should hold after the instruction
    function automatic void ref_rmw(input logic [2:0] o, input logic [7:0] m, input logic [7:0] p,
                                    output logic [7:0] r, output logic [7:0] f, output bit legal);
        int v;
        int c;
        v = int'(m);
        c = int'(p[P_C]);
        legal = 1'b1;
        case (o)
            OP_ASL: begin c = v / 128; v = (v * 2) % 256; end
            OP_ROL: begin c = v / 128; v = (v * 2 + int'(p[P_C])) % 256; end
            OP_LSR: begin c = v % 2; v = v / 2; end
            OP_ROR: begin c = v % 2; v = v / 2 + 128 * int'(p[P_C]); end
            OP_DEC: v = (v + 255) % 256;
            OP_INC: v = (v + 1) % 256;
            default: legal = 1'b0;
        endcase
        r = 8'(v);
        f = p;
        f[P_C] = (c != 0);
        f[P_Z] = (v == 0);
        f[P_N] = (v >= 128);
        f[P_V] = p[P_V];
    endfunction

    task automatic run_rmw(input string tag, input logic [2:0] o, input logic [AW-1:0] a,
                           input logic [7:0] m, input logic [7:0] p, input int dly, input bit poke,
                           input bit exact, input logic [7:0] exp_w, input logic [7:0] exp_p);
        logic [7:0] rr, ff;
        bit lg, tmo;
        int cyc, w, scyc, nrd, ovl, badaddr, blow;
        int exp_cyc;
        logic [7:0] wq[$];
        ref_rmw(o, m, p, rr, ff, lg);
        tmo = lg && (dly > WAIT_MAX);
        start = 1'b1; op = o; addr = a; p_in = p;
        @(posedge clk); #1;
        start = 1'b0; op = 3'($urandom); addr = AW'($urandom); p_in = 8'($urandom);
        cyc = 1; w = 0; scyc = 0; nrd = 0; ovl = 0; badaddr = 0; blow = 0;
        while (!done && cyc < 400) begin
            start = poke && (cyc == 2);
            if (start) op = 3'b100;
            if (!busy) blow++;
            if (mem_rd && mem_we) ovl++;
            mem_ack = 1'b0;
            mem_rdata = 8'($urandom);
            if (mem_rd || mem_we) begin
                scyc++;
                if (mem_addr !== a) badaddr++;
                if (w == dly) begin
                    mem_ack = 1'b1;
                    if (mem_rd) begin mem_rdata = m; nrd++; end
                    else wq.push_back(mem_wdata);
                    w = 0;
                end else begin
                    w++;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        mem_ack = 1'b0; start = 1'b0;
        chk({tag, ":done"}, 32'(done), 32'd1);
        if (!lg) exp_cyc = 1;
        else if (tmo) exp_cyc = WAIT_MAX + 2;
        else exp_cyc = 4 + D + dly * (2 + D);
        chk({tag, ":done_cycle"}, 32'(cyc), 32'(exp_cyc));
        chk({tag, ":err"}, 32'(err), 32'(!lg || tmo));
        chk({tag, ":p_we"}, 32'(p_we), 32'(lg && !tmo));
        chk({tag, ":busy_held"}, 32'(blow), 32'd0);
        chk({tag, ":overlap"}, 32'(ovl), 32'd0);
        chk({tag, ":bad_addr"}, 32'(badaddr), 32'd0);
        if (!lg) chk({tag, ":strobe_cycles"}, 32'(scyc), 32'd0);
        else if (tmo) begin
            chk({tag, ":strobe_cycles"}, 32'(scyc), 32'(WAIT_MAX + 1));
            chk({tag, ":reads"}, 32'(nrd), 32'd0);
        end else begin
            chk({tag, ":strobe_cycles"}, 32'(scyc), 32'((2 + D) * (dly + 1)));
            chk({tag, ":reads"}, 32'(nrd), 32'd1);
            chk({tag, ":writes"}, 32'(wq.size()), 32'(1 + D));
            if (wq.size() == 1 + D) begin
                chk({tag, ":result"}, 32'(wq[D]), 32'(rr));
                if (D == 1) chk({tag, ":dummy"}, 32'(wq[0]), 32'(m));
            end
            chk({tag, ":p_out"}, 32'(p_out), 32'(ff));
            if (exact) begin
                chk({tag, ":result_tp"}, 32'(rr), 32'(exp_w));
                chk({tag, ":p_out_tp"}, 32'(p_out), 32'(exp_p));
            end
        end
        @(posedge clk); #1;
        chk({tag, ":after"}, {28'd0, done, busy, p_we, mem_rd | mem_we}, 32'd0);
    endtask

    initial begin
        int nw, hold, cyc;
        logic [2:0] ro;
        rst = 1'b1; start = 1'b0; op = '0; addr = '0; p_in = '0;
        mem_rdata = '0; mem_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_alu_mode", 32'(alu_mode), 32'h4);
        chk("reset_outs", {busy, done, err, p_we, mem_rd, mem_we, 26'd0}, 32'd0);
        chk("reset_data", {mem_addr, mem_wdata, p_out}, 32'd0);
        chk("reset_alu_ops", {alu_b, alu_p}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_rmw("asl", OP_ASL, 16'h0200, 8'h81, 8'h00, 0, 1'b0, 1'b1, 8'h02, 8'h01);
        run_rmw("inc", OP_INC, 16'h0201, 8'hFF, 8'h01, 0, 1'b0, 1'b1, 8'h00, 8'h03);
        run_rmw("ror", OP_ROR, 16'h1234, 8'h01, 8'h01, 0, 1'b0, 1'b1, 8'h80, 8'h81);
        run_rmw("lsr_wait3", OP_LSR, 16'h4000, 8'h55, 8'h00, 3, 1'b0, 1'b1, 8'h2A, 8'h01);
        run_rmw("illegal100", 3'b100, 16'h0010, 8'h12, 8'h00, 0, 1'b0, 1'b0, 8'h00, 8'h00);
        run_rmw("illegal101", 3'b101, 16'h0011, 8'h12, 8'hC3, 0, 1'b0, 1'b0, 8'h00, 8'h00);
        run_rmw("dec_poke", OP_DEC, 16'h00FF, 8'h00, 8'h00, 1, 1'b1, 1'b1, 8'hFF, 8'h80);

        // Reset while the result write is waiting for ack
        start = 1'b1; op = OP_INC; addr = 16'h0300; p_in = 8'h00;
        @(posedge clk); #1;
        start = 1'b0;
        nw = 0; hold = 0; cyc = 0;
        while (hold < 3 && cyc < 100) begin
            mem_ack = 1'b0;
            if (mem_rd) begin mem_ack = 1'b1; mem_rdata = 8'h7F; end
            else if (mem_we && nw < D) begin mem_ack = 1'b1; nw++; end
            else if (mem_we) hold++;
            @(posedge clk); #1;
            cyc++;
        end
        mem_ack = 1'b0;
        chk("rst_write_reached", 32'(hold), 32'd3);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_mid_op", {28'd0, mem_we, busy, done, p_we}, 32'd0);
        @(posedge clk); #1;
        chk("rst_no_done", {30'd0, done, p_we}, 32'd0);

        run_rmw("rol_after_rst", OP_ROL, 16'h0400, 8'h80, 8'h00, 0, 1'b0, 1'b1, 8'h00, 8'h03);
        run_rmw("timeout", OP_ASL, 16'h0500, 8'h01, 8'h40, 1000, 1'b0, 1'b0, 8'h00, 8'h00);

        for (int i = 0; i < 16; i++) begin
            ro = 3'($urandom_range(0, 7));
            run_rmw("rand", ro, AW'($urandom), 8'($urandom), 8'($urandom),
                    int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), 1'b0, 8'h00, 8'h00);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
